ps2_kb_ctrl: RTL

- Link controller between the PS/2 byte receiver, a PS/2 byte transmitter and user logic.
- Waits for the keyboard power-on self-test (BAT) result and sequences the LED command (0xED + argument) with ACK, resend, retry and timeout handling.
- Routes non-protocol bytes into a scan-code decoder that emits key events with extended and release flags.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_scan_decoder.sv | 56 +++++
 rtl/ps2_kb_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared byte constants, controller state encoding and protocol-byte classification
// for the PS/2 keyboard link controller.
package ps2_pkg;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] RSP_ACK     = 8'hFA;
   localparam logic [7:0] RSP_RESEND  = 8'hFE;
   localparam logic [7:0] RSP_ECHO    = 8'hEE;
   localparam logic [7:0] BAT_OK      = 8'hAA;
   localparam logic [7:0] BAT_ERR     = 8'hFC;
   localparam logic [7:0] PFX_EXT     = 8'hE0;
   localparam logic [7:0] PFX_REL     = 8'hF0;

   typedef enum logic [2:0] {
      WAIT_BAT  = 3'd0,
      IDLE      = 3'd1,
      SEND_CMD  = 3'd2,
      WAIT_ACK1 = 3'd3,
      SEND_ARG  = 3'd4,
      WAIT_ACK2 = 3'd5,
      FAIL      = 3'd6
   } ctrl_state_e;

   // Bytes owned by the link protocol; they never reach the scan decoder.
   function automatic logic is_protocol(input logic [7:0] b);
      return (b == RSP_ACK) || (b == RSP_RESEND) || (b == RSP_ECHO) ||
             (b == BAT_OK)  || (b == BAT_ERR);
   endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// Turns received scan bytes into key events, folding E0/F0 prefixes into
// the ext/rel flags of the following code byte.
module ps2_scan_decoder
   import ps2_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       en,
   input  logic       clr,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   input  logic       rx_err,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_rel
);

   logic ext_q;
   logic rel_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         key_valid <= 1'b0;
         key_code  <= 8'h00;
         key_ext   <= 1'b0;
         key_rel   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (clr) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
         end else if (en && rx_valid) begin
            // A corrupted byte may have been a prefix; drop any partial sequence.
            if (rx_err) begin
               ext_q <= 1'b0;
               rel_q <= 1'b0;
            end else if (rx_byte == PFX_EXT) begin
               ext_q <= 1'b1;
            end else if (rx_byte == PFX_REL) begin
               rel_q <= 1'b1;
            end else if (!is_protocol(rx_byte)) begin
               key_valid <= 1'b1;
               key_code  <= rx_byte;
               key_ext   <= ext_q;
               key_rel   <= rel_q;
               ext_q     <= 1'b0;
               rel_q     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/ps2_kb_ctrl.sv
// PS/2 keyboard link controller: BAT wait, LED command sequencing with
// ACK/resend/retry/timeout, and routing of scan bytes to the decoder.
module ps2_kb_ctrl
   import ps2_pkg::*;
#(
   parameter int ACK_TIMEOUT = 2_000_000,
   parameter int BAT_TIMEOUT = 100_000_000,
   parameter int MAX_RETRY   = 3
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   input  logic       rx_err,
   output logic       rx_rst,
   output logic       tx_start,
   output logic [7:0] tx_byte,
   input  logic       tx_done,
   input  logic       tx_fail,
   input  logic       led_req,
   input  logic [2:0] led_val,
   output logic       led_ack,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_rel,
   output logic       kb_ready,
   output logic       kb_fail,
   output logic [2:0] state_dbg
);

   // Handshakes: rx_valid, tx_done, tx_fail and every output pulse are
   // single-cycle strobes with no back-pressure; tx_byte is valid for the
   // whole time the controller sits in a send state.

   localparam int BAT_W = $clog2(BAT_TIMEOUT + 1);
   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 2);

   localparam logic [BAT_W-1:0] BAT_MAX = BAT_W'(BAT_TIMEOUT);
   localparam logic [BAT_W-1:0] BAT_LIM = BAT_W'(BAT_TIMEOUT - 1);
   localparam logic [ACK_W-1:0] ACK_MAX = ACK_W'(ACK_TIMEOUT);
   localparam logic [ACK_W-1:0] ACK_LIM = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

   ctrl_state_e      state_q, state_d;
   logic [BAT_W-1:0] bat_cnt_q, bat_cnt_d;
   logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic [2:0]       led_q, led_d;
   logic             tx_start_d, led_ack_d, rx_rst_d;
   logic             dec_clr, dec_en, resend, rx_ok, active;

   assign rx_ok  = rx_valid && !rx_err;
   assign active = (state_q == IDLE)      || (state_q == SEND_CMD) ||
                   (state_q == WAIT_ACK1) || (state_q == SEND_ARG) ||
                   (state_q == WAIT_ACK2);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= WAIT_BAT;
         bat_cnt_q <= '0;
         ack_cnt_q <= '0;
         retry_q   <= '0;
         led_q     <= '0;
         tx_start  <= 1'b0;
         led_ack   <= 1'b0;
         rx_rst    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bat_cnt_q <= bat_cnt_d;
         ack_cnt_q <= ack_cnt_d;
         retry_q   <= retry_d;
         led_q     <= led_d;
         tx_start  <= tx_start_d;
         led_ack   <= led_ack_d;
         rx_rst    <= rx_rst_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bat_cnt_d  = bat_cnt_q;
      ack_cnt_d  = ack_cnt_q;
      retry_d    = retry_q;
      led_d      = led_q;
      tx_start_d = 1'b0;
      led_ack_d  = 1'b0;
      rx_rst_d   = 1'b0;
      dec_clr    = 1'b0;
      resend     = 1'b0;

      case (state_q)
         WAIT_BAT: begin
            if (bat_cnt_q != BAT_MAX) bat_cnt_d = bat_cnt_q + 1'b1;
            if (rx_valid) begin
               if (rx_ok && rx_byte == BAT_OK) begin
                  state_d = IDLE;
               end else if (rx_ok && rx_byte == BAT_ERR) begin
                  state_d = FAIL;
               end else begin
                  rx_rst_d  = 1'b1;
                  bat_cnt_d = '0;
               end
            end else if (bat_cnt_q == BAT_LIM) begin
               state_d = FAIL;
            end
         end

         IDLE: begin
            if (led_req) begin
               led_d      = led_val;
               retry_d    = '0;
               state_d    = SEND_CMD;
               tx_start_d = 1'b1;
            end
         end

         SEND_CMD, SEND_ARG: begin
            if (tx_done) begin
               state_d   = (state_q == SEND_CMD) ? WAIT_ACK1 : WAIT_ACK2;
               ack_cnt_d = '0;
            end else if (tx_fail) begin
               resend = 1'b1;
            end
         end

         WAIT_ACK1, WAIT_ACK2: begin
            if (ack_cnt_q != ACK_MAX) ack_cnt_d = ack_cnt_q + 1'b1;
            if (rx_ok && rx_byte == RSP_ACK) begin
               if (state_q == WAIT_ACK1) begin
                  state_d    = SEND_ARG;
                  tx_start_d = 1'b1;
               end else begin
                  state_d   = IDLE;
                  led_ack_d = 1'b1;
               end
            end else if (rx_valid && (rx_err || rx_byte == RSP_RESEND)) begin
               resend = 1'b1;
            end else if (ack_cnt_q == ACK_LIM) begin
               resend = 1'b1;
            end
         end

         FAIL: begin
         end

         default: state_d = FAIL;
      endcase

      // Any resend restarts the whole command from 0xED.
      if (resend) begin
         if (retry_q == RTY_MAX) begin
            state_d = FAIL;
         end else begin
            retry_d    = retry_q + 1'b1;
            state_d    = SEND_CMD;
            tx_start_d = 1'b1;
         end
      end

      // Keyboard-originated BAT results override whatever command is in progress.
      if (active && rx_ok && (rx_byte == BAT_OK || rx_byte == BAT_ERR)) begin
         state_d    = (rx_byte == BAT_OK) ? IDLE : FAIL;
         dec_clr    = (rx_byte == BAT_OK);
         tx_start_d = 1'b0;
         led_ack_d  = 1'b0;
      end
   end

   always_comb begin
      kb_ready  = active;
      kb_fail   = (state_q == FAIL);
      dec_en    = active;
      state_dbg = state_q;
      tx_byte   = 8'h00;
      if (state_q == SEND_CMD) tx_byte = CMD_SET_LED;
      if (state_q == SEND_ARG) tx_byte = {5'b00000, led_q};
   end

   ps2_scan_decoder u_dec (
      .CLK       (CLK),
      .RST       (RST),
      .en        (dec_en),
      .clr       (dec_clr),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .rx_err    (rx_err),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .key_rel   (key_rel)
   );

endmodule
